// File: rtl/retry_budget_ctrl.sv
// Per-ID retry budget: forwards retries until an ID exhausts its budget,
// then consumes further retries of that ID and raises a sticky fault.
module retry_budget_ctrl #(
    parameter int IDSize       = 2,
    parameter int MaxRetries   = 3,
    parameter int DropCntWidth = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    issue_valid_i,
    input  logic [IDSize-1:0]       issue_id_i,
    input  logic                    retry_valid_i,
    input  logic [IDSize-1:0]       retry_id_i,
    output logic                    retry_ready_o,
    output logic                    retry_valid_o,
    output logic [IDSize-1:0]       retry_id_o,
    input  logic                    retry_ready_i,
    input  logic                    clear_i,
    output logic                    fault_o,
    output logic [IDSize-1:0]       fault_id_o,
    output logic [DropCntWidth-1:0] drop_cnt_o
);

    localparam int NumIds = 2 ** IDSize;
    localparam int CntW   = $clog2(MaxRetries + 1);

    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxRetries);

    localparam logic ST_OK    = 1'b0;
    localparam logic ST_FAULT = 1'b1;

    logic [CntW-1:0]         cnt_q [NumIds];
    logic [CntW-1:0]         cur_cnt;
    logic                    forward;
    logic                    drop;
    logic                    bump;
    logic                    state_q;
    logic                    state_d;
    logic [IDSize-1:0]       fault_id_q;
    logic [DropCntWidth-1:0] drop_cnt_q;

    // Decision always looks at the pre-update count, even when a clear
    // or issue hits the same ID in this cycle.
    assign cur_cnt = cnt_q[retry_id_i];
    assign forward = retry_valid_i & (cur_cnt < MaxCnt);
    assign drop    = retry_valid_i & (cur_cnt == MaxCnt);
    assign bump    = forward & retry_ready_i;

    assign retry_valid_o = forward;
    assign retry_id_o    = retry_id_i;
    assign retry_ready_o = drop ? 1'b1 : retry_ready_i;

    assign fault_o    = (state_q == ST_FAULT);
    assign fault_id_o = fault_id_q;
    assign drop_cnt_o = drop_cnt_q;

    // Issue clear beats a retry increment on the same ID.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumIds; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumIds; i++) begin
                if (clear_i) begin
                    cnt_q[i] <= '0;
                end else if (issue_valid_i &&
                             issue_id_i == IDSize'(i)) begin
                    cnt_q[i] <= '0;
                end else if (bump &&
                             retry_id_i == IDSize'(i)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OK:    if (drop) state_d = ST_FAULT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_OK;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_OK;
            fault_id_q <= '0;
            drop_cnt_q <= '0;
        end else if (clear_i) begin
            state_q    <= ST_OK;
            fault_id_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (drop) begin
                fault_id_q <= retry_id_i;
                if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_retry_budget_ctrl.sv
// Directed bench for retry_budget_ctrl with a 2-bit drop counter so that
// saturation is reachable in a short run.
module tb_retry_budget_ctrl;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic [1:0] issue_id;
    logic       retry_valid_i;
    logic [1:0] retry_id_i;
    logic       retry_ready_o;
    logic       retry_valid_o;
    logic [1:0] retry_id_o;
    logic       retry_ready_i;
    logic       clear;
    logic       fault;
    logic [1:0] fault_id;
    logic [1:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    retry_budget_ctrl #(
        .IDSize      (2),
        .MaxRetries  (3),
        .DropCntWidth(2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .issue_valid_i(issue_valid),
        .issue_id_i   (issue_id),
        .retry_valid_i(retry_valid_i),
        .retry_id_i   (retry_id_i),
        .retry_ready_o(retry_ready_o),
        .retry_valid_o(retry_valid_o),
        .retry_id_o   (retry_id_o),
        .retry_ready_i(retry_ready_i),
        .clear_i      (clear),
        .fault_o      (fault),
        .fault_id_o   (fault_id),
        .drop_cnt_o   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stat(input string tag, input logic f,
                            input logic [1:0] fid, input logic [1:0] dc);
        chk({tag, "_fault"}, 32'(fault), 32'(f));
        chk({tag, "_fid"}, 32'(fault_id), 32'(fid));
        chk({tag, "_dcnt"}, 32'(drop_cnt), 32'(dc));
    endtask

    // One retry cycle: present, check combinational outputs, clock it in.
    task automatic do_retry(input string tag, input logic [1:0] id,
                            input logic rdy, input logic exp_v);
        retry_valid_i = 1'b1;
        retry_id_i    = id;
        retry_ready_i = rdy;
        #1;
        chk({tag, "_vo"}, 32'(retry_valid_o), 32'(exp_v));
        chk({tag, "_ido"}, 32'(retry_id_o), 32'(id));
        chk({tag, "_rdyo"}, 32'(retry_ready_o), 32'(exp_v ? rdy : 1'b1));
        tick();
        retry_valid_i = 1'b0;
        retry_ready_i = 1'b0;
    endtask

    task automatic do_issue(input logic [1:0] id);
        issue_valid = 1'b1;
        issue_id    = id;
        tick();
        issue_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        issue_valid   = 1'b0;
        issue_id      = 2'd0;
        retry_valid_i = 1'b0;
        retry_id_i    = 2'd0;
        retry_ready_i = 1'b0;
        clear         = 1'b0;
        #2;
        chk_stat("rst", 1'b0, 2'd0, 2'd0);
        chk("rst_vo_idle", 32'(retry_valid_o), 32'd0);

        // Requests during reset are forwarded; counts stay at zero.
        do_retry("rst_fwd", 2'd2, 1'b1, 1'b1);
        do_retry("rst_fwd2", 2'd2, 1'b1, 1'b1);
        #2 rst = 1'b0;
        tick();
        chk_stat("post_rst", 1'b0, 2'd0, 2'd0);

        // Budget exhaustion on ID 2.
        do_retry("b2_r1", 2'd2, 1'b1, 1'b1);
        do_retry("b2_r2", 2'd2, 1'b1, 1'b1);
        do_retry("b2_r3", 2'd2, 1'b1, 1'b1);
        chk_stat("b2_pre", 1'b0, 2'd0, 2'd0);
        do_retry("b2_drop", 2'd2, 1'b1, 1'b0);
        chk_stat("b2_post", 1'b1, 2'd2, 2'd1);

        // Issue resets the budget of ID 1.
        do_retry("i1_r1", 2'd1, 1'b1, 1'b1);
        do_retry("i1_r2", 2'd1, 1'b1, 1'b1);
        do_retry("i1_r3", 2'd1, 1'b1, 1'b1);
        do_issue(2'd1);
        do_retry("i1_after", 2'd1, 1'b1, 1'b1);
        chk_stat("i1_stat", 1'b1, 2'd2, 2'd1);

        // Same-ID issue and retry: forwarded, clear wins.
        do_retry("s3_r1", 2'd3, 1'b1, 1'b1);
        do_retry("s3_r2", 2'd3, 1'b1, 1'b1);
        issue_valid = 1'b1;
        issue_id    = 2'd3;
        do_retry("s3_same", 2'd3, 1'b1, 1'b1);
        issue_valid = 1'b0;
        do_retry("s3_c1", 2'd3, 1'b1, 1'b1);
        do_retry("s3_c2", 2'd3, 1'b1, 1'b1);
        do_retry("s3_c3", 2'd3, 1'b1, 1'b1);
        do_retry("s3_drop", 2'd3, 1'b1, 1'b0);
        chk_stat("s3_stat", 1'b1, 2'd3, 2'd2);

        // Different IDs: issue 2 (cnt 3) with retry 1 (cnt 1).
        issue_valid = 1'b1;
        issue_id    = 2'd2;
        do_retry("d_same", 2'd1, 1'b1, 1'b1);
        issue_valid = 1'b0;
        do_retry("d_id2", 2'd2, 1'b1, 1'b1);
        do_retry("d_id1", 2'd1, 1'b1, 1'b1);
        do_retry("d_id1_drop", 2'd1, 1'b1, 1'b0);
        chk_stat("d_stat", 1'b1, 2'd1, 2'd3);

        // Back-pressure on ID 0 must not consume budget.
        for (int i = 0; i < 5; i++) begin
            do_retry("bp_hold", 2'd0, 1'b0, 1'b1);
        end
        do_retry("bp_acc", 2'd0, 1'b1, 1'b1);
        do_retry("bp_r2", 2'd0, 1'b1, 1'b1);
        do_retry("bp_r3", 2'd0, 1'b1, 1'b1);
        do_retry("bp_drop", 2'd0, 1'b1, 1'b0);
        chk_stat("bp_stat", 1'b1, 2'd0, 2'd3);

        // Saturation, then clear with a drop in the same cycle.
        do_retry("sat_d1", 2'd1, 1'b1, 1'b0);
        do_retry("sat_d2", 2'd0, 1'b1, 1'b0);
        chk_stat("sat_stat", 1'b1, 2'd0, 2'd3);
        clear = 1'b1;
        do_retry("clr_drop", 2'd0, 1'b1, 1'b0);
        clear = 1'b0;
        chk_stat("clr_stat", 1'b0, 2'd0, 2'd0);
        do_retry("clr_id0", 2'd0, 1'b1, 1'b1);
        do_retry("clr_id1", 2'd1, 1'b1, 1'b1);
        do_retry("clr_id1b", 2'd1, 1'b1, 1'b1);
        chk_stat("clr_stat2", 1'b0, 2'd0, 2'd0);

        // Raise fault via ID 0 (cnt 1), then async reset mid-transfer.
        do_retry("ar_f1", 2'd0, 1'b1, 1'b1);
        do_retry("ar_f2", 2'd0, 1'b1, 1'b1);
        do_retry("ar_fd", 2'd0, 1'b1, 1'b0);
        chk_stat("ar_pre", 1'b1, 2'd0, 2'd1);
        retry_valid_i = 1'b1;
        retry_id_i    = 2'd1;
        retry_ready_i = 1'b0;
        #1;
        chk("ar_hold_vo", 32'(retry_valid_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_stat("ar_async", 1'b0, 2'd0, 2'd0);
        chk("ar_async_vo", 32'(retry_valid_o), 32'd1);
        tick();
        #2 rst = 1'b0;
        retry_valid_i = 1'b0;
        tick();
        do_retry("ar_n1", 2'd1, 1'b1, 1'b1);
        do_retry("ar_n2", 2'd1, 1'b1, 1'b1);
        do_retry("ar_n3", 2'd1, 1'b1, 1'b1);
        do_retry("ar_nd", 2'd1, 1'b1, 1'b0);
        chk_stat("ar_end", 1'b1, 2'd1, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
